// File: rtl/dma_block_writer.sv
// dma_block_writer: serialises one captured block into consecutive single-word memory writes.
// Optional block checksum enabled by defining DMA_WR_CHECKSUM_EN.
module dma_block_writer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int BLOCK_SIZE = 25
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             blk_valid,
    output logic                             blk_ready,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] blk_data,
    input  logic [ADDR_WIDTH-1:0]            blk_base,
    output logic                             mem_enable,
    output logic                             mem_rw,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [DATA_WIDTH-1:0]            mem_data,
    input  logic                             mem_ready,
    output logic                             busy,
    output logic                             done,
    output logic [DATA_WIDTH-1:0]            checksum
);
    localparam int IW = $clog2(BLOCK_SIZE + 1);
    localparam logic [IW-1:0] LAST = IW'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                          state_q, state_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic [BLOCK_SIZE*DATA_WIDTH-1:0] buf_q, buf_d;
    logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0]           wdata_q, wdata_d;
    logic                            en_q, en_d;
    logic                            rdy_q, rdy_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            capture;
    logic                            accept;

    // The remaining words live in a shift register so the next word is always the low slice.
    assign capture     = (state_q == IDLE) && blk_valid && rdy_q;
    assign accept      = en_q && mem_ready;
    assign blk_ready   = rdy_q;
    assign mem_enable  = en_q;
    assign mem_rw      = 1'b0;
    assign mem_address = addr_q;
    assign mem_data    = wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // Next-state and registered-output decode for the IDLE/WRITE/DONE sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        en_d    = en_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (capture) begin
                state_d = WRITE;
                idx_d   = '0;
                buf_d   = blk_data >> DATA_WIDTH;
                wdata_d = blk_data[DATA_WIDTH-1:0];
                addr_d  = blk_base;
                en_d    = 1'b1;
                rdy_d   = 1'b0;
                busy_d  = 1'b1;
            end
            WRITE: if (accept) begin
                if (idx_q == LAST) begin
                    state_d = DONE;
                    en_d    = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    wdata_d = buf_q[DATA_WIDTH-1:0];
                    buf_d   = buf_q >> DATA_WIDTH;
                end
            end
            DONE: begin
                state_d = IDLE;
                rdy_d   = 1'b1;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            en_q    <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            en_q    <= en_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef DMA_WR_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;

    assign sum_d    = capture ? '0 : accept ? sum_q + wdata_q : sum_q;
    assign checksum = sum_q;

    // Running sum of accepted words, restarted on every block capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_dma_block_writer.sv
// tb_dma_block_writer: directed bench for dma_block_writer with hand-computed expectations.
module tb_dma_block_writer;
    logic         clk;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [399:0] blk_data;
    logic [15:0]  blk_base;
    logic         mem_enable;
    logic         mem_rw;
    logic [15:0]  mem_address;
    logic [15:0]  mem_data;
    logic         mem_ready;
    logic         busy;
    logic         done;
    logic [15:0]  checksum;

    int          total;
    int          bad;
    int          stall_left[25];
    logic [15:0] exp_w[25];
    logic [15:0] ebase;

    dma_block_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_data   (blk_data),
        .blk_base   (blk_base),
        .mem_enable (mem_enable),
        .mem_rw     (mem_rw),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a block whose word i is seed+i at the given base.
    task automatic offer(input logic [15:0] base, input logic [15:0] seed);
        for (int i = 0; i < 25; i++) begin
            exp_w[i] = seed + 16'(i);
            blk_data[i*16 +: 16] = exp_w[i];
        end
        ebase     = base;
        blk_base  = base;
        blk_valid = 1'b1;
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_ready"}, blk_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_en"}, mem_enable, 0);
    endtask

    // Follow one block from capture to DONE (or stop after abort_at acceptances).
    task automatic run_blk(input int exp_k, input logic [15:0] exp_ck, input bit meddle,
                           input bit hold, input int abort_at);
        int k;
        int n;
        logic [15:0] ea;
        k = 0;
        n = 0;
        while (n < 25 && k < 200) begin
            @(negedge clk);
            k++;
            if (!hold && k == 1) blk_valid = 1'b0;
            if (meddle && k == 4) begin
                blk_valid = 1'b1;
                blk_base  = 16'h5555;
                blk_data  = '1;
            end
            if (meddle && k == 5) blk_valid = 1'b0;
            mem_ready = (stall_left[n] == 0);
            if (!mem_ready) stall_left[n]--;
            ea = ebase + 16'(n);
            check("w_en", mem_enable, 1);
            check("w_rw", mem_rw, 0);
            check("w_addr", mem_address, ea);
            check("w_data", mem_data, exp_w[n]);
            check("w_done", done, 0);
            check("w_ready", blk_ready, 0);
            check("w_busy", busy, 1);
            if (mem_ready) n++;
            if (n == abort_at) return;
        end
        check("timeout", n, 25);
        @(negedge clk);
        k++;
        check("done_pulse", done, 1);
        check("done_cycle", k, exp_k);
        check("done_en", mem_enable, 0);
        check("done_busy", busy, 1);
        check("done_ready", blk_ready, 0);
`ifdef DMA_WR_CHECKSUM_EN
        check("checksum", checksum, exp_ck);
`else
        check("checksum", checksum, 16'h0 & exp_ck);
`endif
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        blk_valid = 1'b0;
        blk_data  = '0;
        blk_base  = '0;
        mem_ready = 1'b0;
        foreach (stall_left[i]) stall_left[i] = 0;
        repeat (2) @(negedge clk);
        check("rst_ready", blk_ready, 1);
        check("rst_en", mem_enable, 0);
        check("rst_rw", mem_rw, 0);
        check("rst_addr", mem_address, 0);
        check("rst_data", mem_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ck", checksum, 0);
        rst_n = 1'b1;
        @(negedge clk);
        idle_check("idle0");

        offer(16'h0100, 16'h0000);
        run_blk(26, 16'h012C, 0, 0, -1);
        @(negedge clk);
        idle_check("basic_end");

        stall_left[5]  = 3;
        stall_left[24] = 1;
        offer(16'h0100, 16'h0040);
        run_blk(30, 16'h076C, 0, 0, -1);
        @(negedge clk);
        idle_check("stall_end");

        offer(16'hFFF0, 16'h1000);
        run_blk(26, 16'h912C, 0, 0, -1);
        @(negedge clk);
        idle_check("wrap_end");

        offer(16'h0400, 16'h0300);
        run_blk(26, 16'h4C2C, 1, 0, -1);
        @(negedge clk);
        idle_check("meddle_end");
        @(negedge clk);
        idle_check("meddle_idle");

        offer(16'h0200, 16'h0007);
        run_blk(0, 16'h0000, 0, 0, 11);
        @(negedge clk);
        check("pre_rst_addr", mem_address, 16'h020B);
        check("pre_rst_data", mem_data, 16'h0012);
        rst_n = 1'b0;
        #1;
        check("abort_en", mem_enable, 0);
        check("abort_ready", blk_ready, 1);
        check("abort_addr", mem_address, 0);
        check("abort_data", mem_data, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ck", checksum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle_check("post_rst");
        @(negedge clk);
        idle_check("post_rst2");

        offer(16'h0600, 16'hA000);
        run_blk(26, 16'hA12C, 0, 1, -1);
        offer(16'h0700, 16'h0B00);
        @(negedge clk);
        idle_check("b2b_gap");
        run_blk(26, 16'h142C, 0, 0, -1);
        @(negedge clk);
        idle_check("b2b_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
